mips_data_bridge: RTL

Data-side bus bridge between the `mips_cpu` Harvard data port and a shared Avalon-MM memory with wait states. It turns the CPU's single-cycle data access model into variable-latency memory transactions. It does this by generating the CPU's `clk_enable`, so the pipeline freezes until each access completes. A one-entry read buffer lets repeated reads of the same word, which the CPU issues every cycle because `data_read` is tied high, proceed without stalling.

---
 rtl/mips_data_bridge.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mips_data_bridge.sv
// Data-side bridge from the single-cycle CPU data port to a wait-stated Avalon-MM memory.
// Freezes the CPU through cpu_clk_enable; a one-entry write-through buffer absorbs repeated reads.
module mips_data_bridge #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ext_enable,
  input  logic                       flush_buffer,
  input  logic [ADDR_WIDTH-1:0]      cpu_address,
  input  logic                       cpu_read,
  input  logic                       cpu_write,
  input  logic [31:0]                cpu_writedata,
  output logic [31:0]                cpu_readdata,
  output logic                       cpu_clk_enable,
  output logic [ADDR_WIDTH-1:0]      avm_address,
  output logic                       avm_read,
  output logic                       avm_write,
  output logic [31:0]                avm_writedata,
  output logic [3:0]                 avm_byteenable,
  input  logic [31:0]                avm_readdata,
  input  logic                       avm_waitrequest,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned WA_W   = ADDR_WIDTH - 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_nxt;
  logic                       r_buf_valid;
  logic [WA_W-1:0]            r_buf_addr;
  logic [DATA_W-1:0]          r_buf_data;
  logic [WA_W-1:0]            r_req_addr;
  logic [DATA_W-1:0]          r_req_wdata;
  logic                       r_req_is_write;
  logic [DATA_W-1:0]          r_resp_data;
  logic [STALL_CNT_WIDTH-1:0] r_stall_count;

  logic              w_hit;
  logic              w_need;
  logic              w_latch;
  logic              w_done;
  logic [DATA_W-1:0] w_done_data;
  logic              w_unused_addr_lsb;

  // Byte offset is irrelevant: all accesses are whole words.
  assign w_unused_addr_lsb = ^cpu_address[1:0];

  assign w_hit       = r_buf_valid && (r_buf_addr == cpu_address[ADDR_WIDTH-1:2]);
  assign w_need      = cpu_write || (cpu_read && !w_hit);
  assign w_done_data = r_req_is_write ? r_req_wdata : avm_readdata;

  // Avalon side is decoded only from state and the latched request.
  assign avm_read       = (r_state == S_BUSY) && !r_req_is_write;
  assign avm_write      = (r_state == S_BUSY) && r_req_is_write;
  assign avm_address    = {r_req_addr, 2'b00};
  assign avm_writedata  = r_req_wdata;
  assign avm_byteenable = 4'hF;
  assign stall_count    = r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    cpu_clk_enable = 1'b0;
    cpu_readdata   = r_resp_data;
    w_latch        = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_need) begin
          cpu_clk_enable = ext_enable;
          cpu_readdata   = w_hit ? r_buf_data : r_resp_data;
        end else if (ext_enable) begin
          w_latch     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!avm_waitrequest) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // Held until an enabled edge consumes the result exactly once.
        cpu_clk_enable = ext_enable;
        if (ext_enable) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_addr     <= '0;
      r_req_wdata    <= '0;
      r_req_is_write <= 1'b0;
      r_resp_data    <= '0;
      r_buf_addr     <= '0;
      r_buf_data     <= '0;
    end else begin
      if (w_latch) begin
        r_req_addr     <= cpu_address[ADDR_WIDTH-1:2];
        r_req_wdata    <= cpu_writedata;
        r_req_is_write <= cpu_write;
      end
      if (w_done) begin
        r_resp_data <= w_done_data;
        r_buf_addr  <= r_req_addr;
        r_buf_data  <= w_done_data;
      end
    end
  end

  // Flush beats a coincident fill; resp_data still carries the value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf_valid <= 1'b0;
    end else if (flush_buffer) begin
      r_buf_valid <= 1'b0;
    end else if (w_done) begin
      r_buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (ext_enable && !cpu_clk_enable && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + STALL_CNT_WIDTH'(1);
    end
  end

endmodule
